// File: rtl/rv32v_ex_mem_buffer_pkg.sv
// ============================================================================
// Module      : rv32v_types_pkg
// Description : Shared types for the rv32v EX->MEM pipeline buffer. Defines the
//               lane geometry constants and the packed entry carried from EX to
//               MEM (scalar writeback plus vector lane payload), together with
//               a helper that yields one entry's mask-set forwarding term.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32v_types_pkg;

    localparam int NUM_LANES = 4;
    localparam int VLANE_W   = 32;

    typedef struct packed {
        logic [31:0]                  pc4;
        logic                         reg_write;
        logic [4:0]                   rd;
        logic [31:0]                  reg_wdata;
        logic [NUM_LANES*VLANE_W-1:0] vdata;
        logic [NUM_LANES-1:0]         vmask;
        logic                         vmskset;
    } exmem_entry_t;

    // Mask lanes an entry contributes to forwarding: only live mask-set entries.
    function automatic logic [NUM_LANES-1:0] fwd_term(input exmem_entry_t e, input logic live);
        return (live && e.vmskset) ? e.vmask : '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32v_ex_mem_buffer_if.sv
// ============================================================================
// Module      : rv32v_ex_mem_buffer_if
// Description : EX->MEM buffer bus. Carries the EX-side push handshake and
//               payload, the MEM-side pop handshake and head payload, flush,
//               the aggregated mask-set forwarding vector and occupancy.
//               master = EX/MEM environment, slave = the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv32v_ex_mem_buffer_if
    import rv32v_types_pkg::*;
#(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  in_pc4;
    logic                         in_reg_write;
    logic [4:0]                   in_rd;
    logic [31:0]                  in_reg_wdata;
    logic [NUM_LANES*VLANE_W-1:0] in_vdata;
    logic [NUM_LANES-1:0]         in_vmask;
    logic                         in_vmskset;
    logic                         out_valid;
    logic                         out_ready;
    logic [31:0]                  out_pc4;
    logic                         out_reg_write;
    logic [4:0]                   out_rd;
    logic [31:0]                  out_reg_wdata;
    logic [NUM_LANES*VLANE_W-1:0] out_vdata;
    logic [NUM_LANES-1:0]         out_vmask;
    logic                         out_vmskset;
    logic [NUM_LANES-1:0]         vmskset_fwd;
    logic [CNT_W-1:0]             occupancy;

    modport master (
        output flush, in_valid, in_pc4, in_reg_write, in_rd, in_reg_wdata,
               in_vdata, in_vmask, in_vmskset, out_ready,
        input  in_ready, out_valid, out_pc4, out_reg_write, out_rd, out_reg_wdata,
               out_vdata, out_vmask, out_vmskset, vmskset_fwd, occupancy
    );

    modport slave (
        input  flush, in_valid, in_pc4, in_reg_write, in_rd, in_reg_wdata,
               in_vdata, in_vmask, in_vmskset, out_ready,
        output in_ready, out_valid, out_pc4, out_reg_write, out_rd, out_reg_wdata,
               out_vdata, out_vmask, out_vmskset, vmskset_fwd, occupancy
    );

endinterface

`default_nettype wire

// File: rtl/rv32v_ex_mem_buffer_ring_ctrl.sv
// ============================================================================
// Module      : exmem_ring_ctrl
// Description : Ring-buffer control for the EX->MEM buffer: read/write
//               pointers, entry count, push/pop/flush arbitration and the
//               per-slot valid vector.
//   CLK, RST      : clock, synchronous active-high reset
//   i_flush       : discard all entries (and any same-cycle push/pop)
//   i_in_valid    : EX offers an entry      o_in_ready : space available
//   i_out_ready   : MEM takes the head      o_out_valid: head is valid
//   o_wr_en       : write storage slot o_wr_ptr this cycle
//   o_rd_ptr      : head slot               o_count    : valid entries
//   o_slot_valid  : per-slot liveness
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exmem_ring_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      i_flush,
    input  logic                      i_in_valid,
    input  logic                      i_out_ready,
    output logic                      o_in_ready,
    output logic                      o_out_valid,
    output logic                      o_wr_en,
    output logic [$clog2(DEPTH)-1:0]  o_wr_ptr,
    output logic [$clog2(DEPTH)-1:0]  o_rd_ptr,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [DEPTH-1:0]          o_slot_valid
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [CNT_W-1:0] r_count_q,  w_count_d;
    logic             w_push;
    logic             w_pop;

    // Ready comes from registered count only, so EX never waits on MEM's ready.
    assign o_in_ready  = !RST && (r_count_q != CNT_W'(DEPTH));
    assign o_out_valid = (r_count_q != '0);
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;
    assign o_wr_en     = w_push && !i_flush;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_push) w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
            if (w_pop)  w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   w_count_d = r_count_q + CNT_W'(1);
                2'b01:   w_count_d = r_count_q - CNT_W'(1);
                default: w_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // A slot is live when its distance from the head (mod DEPTH) is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PTR_W-1:0] w_off;
        assign w_off           = PTR_W'(i) - r_rd_ptr_q;
        assign o_slot_valid[i] = ({1'b0, w_off} < r_count_q);
    end

    assign o_wr_ptr = r_wr_ptr_q;
    assign o_rd_ptr = r_rd_ptr_q;
    assign o_count  = r_count_q;

endmodule

`default_nettype wire

// File: rtl/rv32v_ex_mem_buffer.sv
// ============================================================================
// Module      : rv32v_ex_mem_buffer
// Description : DEPTH-entry EX->MEM pipeline buffer (ring) with valid/ready on
//               both sides, flush, scalar+vector payload and per-lane mask-set
//               forwarding ORed over all in-flight entries.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : rv32v_ex_mem_buffer_if.slave (handshakes, payloads, flush,
//              vmskset_fwd, occupancy)
//   Optional macro RV32V_EXMEM_PERF_EN adds saturating counters:
//     stall_cycles    : cycles with head valid but not consumed
//     flushed_entries : entries discarded by flush
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32v_ex_mem_buffer
    import rv32v_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    rv32v_ex_mem_buffer_if.slave    bus
`ifdef RV32V_EXMEM_PERF_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             flushed_entries
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                 w_wr_en;
    logic [PTR_W-1:0]     w_wr_ptr;
    logic [PTR_W-1:0]     w_rd_ptr;
    logic [CNT_W-1:0]     w_count;
    logic [DEPTH-1:0]     w_slot_valid;
    exmem_entry_t         w_in_entry;
    exmem_entry_t         w_head;
    logic [NUM_LANES-1:0] w_fwd;

    // Payload storage carries no reset; liveness is tracked by the controller.
    exmem_entry_t         r_mem_q [DEPTH];

    exmem_ring_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .CLK          (CLK),
        .RST          (RST),
        .i_flush      (bus.flush),
        .i_in_valid   (bus.in_valid),
        .i_out_ready  (bus.out_ready),
        .o_in_ready   (bus.in_ready),
        .o_out_valid  (bus.out_valid),
        .o_wr_en      (w_wr_en),
        .o_wr_ptr     (w_wr_ptr),
        .o_rd_ptr     (w_rd_ptr),
        .o_count      (w_count),
        .o_slot_valid (w_slot_valid)
    );

    always_comb begin
        w_in_entry           = '0;
        w_in_entry.pc4       = bus.in_pc4;
        w_in_entry.reg_write = bus.in_reg_write;
        w_in_entry.rd        = bus.in_rd;
        w_in_entry.reg_wdata = bus.in_reg_wdata;
        w_in_entry.vdata     = bus.in_vdata;
        w_in_entry.vmask     = bus.in_vmask;
        w_in_entry.vmskset   = bus.in_vmskset;
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) r_mem_q[w_wr_ptr] <= w_in_entry;
    end

    assign w_head            = r_mem_q[w_rd_ptr];
    assign bus.out_pc4       = w_head.pc4;
    assign bus.out_reg_write = w_head.reg_write;
    assign bus.out_rd        = w_head.rd;
    assign bus.out_reg_wdata = w_head.reg_wdata;
    assign bus.out_vdata     = w_head.vdata;
    assign bus.out_vmask     = w_head.vmask;
    assign bus.out_vmskset   = w_head.vmskset;
    assign bus.occupancy     = w_count;

    always_comb begin
        w_fwd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_fwd = w_fwd | fwd_term(r_mem_q[i], w_slot_valid[i]);
        end
    end
    assign bus.vmskset_fwd = w_fwd;

`ifdef RV32V_EXMEM_PERF_EN
    logic [31:0] r_stall_q, w_stall_d;
    logic [31:0] r_flushed_q, w_flushed_d;
    logic [32:0] w_flush_sum;

    always_comb begin
        w_stall_d   = r_stall_q;
        w_flushed_d = r_flushed_q;
        w_flush_sum = {1'b0, r_flushed_q} + 33'(w_count);
        if (bus.out_valid && !bus.out_ready && (r_stall_q != '1)) begin
            w_stall_d = r_stall_q + 32'd1;
        end
        if (bus.flush) begin
            w_flushed_d = w_flush_sum[32] ? '1 : w_flush_sum[31:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_q   <= '0;
            r_flushed_q <= '0;
        end else begin
            r_stall_q   <= w_stall_d;
            r_flushed_q <= w_flushed_d;
        end
    end

    assign stall_cycles    = r_stall_q;
    assign flushed_entries = r_flushed_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv32v_ex_mem_buffer.sv
// ============================================================================
// Module      : tb_rv32v_ex_mem_buffer
// Description : Self-checking bench for rv32v_ex_mem_buffer (DEPTH=2). A
//               queue scoreboard models the buffer contents; a vector table
//               adds hand-derived occupancy/in_ready expectations. Optional
//               macro RV32V_EXMEM_PERF_EN enables the counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32v_ex_mem_buffer;
    import rv32v_types_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32v_ex_mem_buffer_if #(.DEPTH(DEPTH)) bus ();

`ifdef RV32V_EXMEM_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flushed_entries;
`endif

    rv32v_ex_mem_buffer #(.DEPTH(DEPTH)) dut (
        .CLK             (clk),
        .RST             (rst),
        .bus             (bus)
`ifdef RV32V_EXMEM_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flushed_entries (flushed_entries)
`endif
    );

    typedef struct {
        logic       rst;
        logic       flush;
        logic       iv;
        logic       ordy;
        logic [4:0] rd;
        logic [3:0] vmask;
        logic       vmskset;
        int         exp_occ;
        logic       exp_ir;
    } vec_t;

    vec_t         vecs[$];
    exmem_entry_t sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, f, iv, ordy, input logic [4:0] rd,
                       input logic [3:0] vm, input logic vs, input int occ, input logic ir);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy; v.rd = rd;
        v.vmask = vm; v.vmskset = vs; v.exp_occ = occ; v.exp_ir = ir;
        vecs.push_back(v);
    endtask

    // Drive one cycle, check against the scoreboard (and optional hand values), then clock.
    task automatic run_cycle(input logic r, f, iv, ordy, input logic [4:0] rd,
                             input logic [3:0] vm, input logic vs,
                             input int exp_occ, input logic exp_ir, input logic use_exp);
        exmem_entry_t e, act;
        logic [3:0]   fwd;
        logic         m_push, m_pop;
        e.pc4       = 32'h1000 + {25'd0, rd, 2'b00};
        e.reg_write = rd[0];
        e.rd        = rd;
        e.reg_wdata = $urandom();
        e.vdata     = {$urandom(), $urandom(), $urandom(), $urandom()};
        e.vmask     = vm;
        e.vmskset   = vs;
        rst              = r;
        bus.flush        = f;
        bus.in_valid     = iv;
        bus.out_ready    = ordy;
        bus.in_pc4       = e.pc4;
        bus.in_reg_write = e.reg_write;
        bus.in_rd        = e.rd;
        bus.in_reg_wdata = e.reg_wdata;
        bus.in_vdata     = e.vdata;
        bus.in_vmask     = e.vmask;
        bus.in_vmskset   = e.vmskset;
        #1;
        fwd = '0;
        foreach (sb[k]) if (sb[k].vmskset) fwd = fwd | sb[k].vmask;
        check("out_valid",   bus.out_valid, sb.size() != 0);
        check("occupancy",   bus.occupancy, sb.size());
        check("in_ready",    bus.in_ready, !r && (sb.size() < DEPTH));
        check("vmskset_fwd", bus.vmskset_fwd, fwd);
        if (sb.size() != 0 && bus.out_valid) begin
            act.pc4 = bus.out_pc4; act.reg_write = bus.out_reg_write; act.rd = bus.out_rd;
            act.reg_wdata = bus.out_reg_wdata; act.vdata = bus.out_vdata;
            act.vmask = bus.out_vmask; act.vmskset = bus.out_vmskset;
            check("head_payload", act, sb[0]);
        end
        if (use_exp) begin
            check("vec_occupancy", bus.occupancy, exp_occ);
            check("vec_in_ready",  bus.in_ready, exp_ir);
        end
        m_push = iv && !r && (sb.size() < DEPTH);
        m_pop  = ordy && (sb.size() != 0);
        @(posedge clk);
        if (r || f) begin
            sb.delete();
        end else begin
            if (m_pop)  void'(sb.pop_front());
            if (m_push) sb.push_back(e);
        end
        #1;
    endtask

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        bus.in_pc4 = '0; bus.in_reg_write = 1'b0; bus.in_rd = '0; bus.in_reg_wdata = '0;
        bus.in_vdata = '0; bus.in_vmask = '0; bus.in_vmskset = 1'b0;
        @(posedge clk); #1;

        //   rst flush iv ordy rd   vmask  vs  occ ir
        add(1, 0, 1, 0, 5'd0,  4'h0, 0, 0, 0);   // reset holds with in_valid=1
        add(1, 0, 1, 0, 5'd0,  4'h0, 0, 0, 0);
        add(0, 0, 0, 0, 5'd0,  4'h0, 0, 0, 1);   // nothing stored
        add(0, 0, 1, 0, 5'd5,  4'h0, 0, 0, 1);   // fill rd=5
        add(0, 0, 1, 0, 5'd7,  4'h0, 0, 1, 1);   // fill rd=7
        add(0, 0, 1, 0, 5'd9,  4'h0, 0, 2, 0);   // full: ignored
        add(0, 0, 0, 1, 5'd0,  4'h0, 0, 2, 0);   // drain rd=5
        add(0, 0, 0, 1, 5'd0,  4'h0, 0, 1, 1);   // drain rd=7
        add(0, 0, 0, 0, 5'd0,  4'h0, 0, 0, 1);
        add(0, 0, 1, 0, 5'd1,  4'h3, 1, 0, 1);   // A
        add(0, 0, 1, 0, 5'd2,  4'h8, 1, 1, 1);   // B
        add(0, 0, 0, 1, 5'd0,  4'h0, 0, 2, 0);   // fwd 1011, pop A
        add(0, 0, 0, 0, 5'd0,  4'h0, 0, 1, 1);   // fwd 1000
        add(0, 0, 1, 0, 5'd3,  4'h4, 0, 1, 1);   // non mask-set entry
        add(0, 0, 0, 0, 5'd0,  4'h0, 0, 2, 0);
        add(0, 1, 1, 1, 5'd4,  4'h0, 0, 2, 0);   // flush at full with push+pop
        add(0, 0, 1, 0, 5'd6,  4'h0, 0, 0, 1);
        add(0, 1, 1, 1, 5'd8,  4'h0, 0, 1, 1);   // flush discards push and pop
        add(0, 0, 1, 0, 5'd10, 4'h0, 0, 0, 1);   // lands in slot 0
        add(0, 0, 0, 1, 5'd0,  4'h0, 0, 1, 1);
        add(0, 0, 0, 0, 5'd0,  4'h0, 0, 0, 1);

        foreach (vecs[i]) begin
            run_cycle(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].ordy, vecs[i].rd,
                      vecs[i].vmask, vecs[i].vmskset, vecs[i].exp_occ, vecs[i].exp_ir, 1'b1);
        end

        // Streaming: one entry per cycle, occupancy steady at 1, pointers wrap.
        for (int k = 0; k < 10; k++) begin
            run_cycle(0, 0, 1, 1, 5'(11 + k), 4'(k), 1'(k % 2), (k == 0) ? 0 : 1, 1'b1, 1'b1);
        end
        run_cycle(0, 0, 0, 1, 5'd0, 4'h0, 0, 1, 1'b1, 1'b1);
        run_cycle(0, 0, 0, 0, 5'd0, 4'h0, 0, 0, 1'b1, 1'b1);

        // Flush mid-stream with pointers away from zero, then refill and drain.
        run_cycle(0, 0, 1, 0, 5'd21, 4'h1, 1, 0, 1'b1, 1'b1);
        run_cycle(0, 0, 0, 1, 5'd0,  4'h0, 0, 1, 1'b1, 1'b1);
        run_cycle(0, 0, 1, 0, 5'd22, 4'h2, 1, 0, 1'b1, 1'b1);
        run_cycle(0, 1, 1, 0, 5'd23, 4'h4, 1, 1, 1'b1, 1'b1);
        run_cycle(0, 0, 1, 0, 5'd24, 4'h8, 1, 0, 1'b1, 1'b1);
        run_cycle(0, 0, 1, 0, 5'd25, 4'h1, 1, 1, 1'b1, 1'b1);
        run_cycle(0, 0, 0, 1, 5'd0,  4'h0, 0, 2, 1'b0, 1'b1);
        run_cycle(0, 0, 0, 1, 5'd0,  4'h0, 0, 1, 1'b1, 1'b1);
        run_cycle(0, 0, 0, 0, 5'd0,  4'h0, 0, 0, 1'b1, 1'b1);

        // Reset mid-stream drops the stored entry.
        run_cycle(0, 0, 1, 0, 5'd26, 4'h0, 0, 0, 1'b1, 1'b1);
        run_cycle(1, 0, 1, 0, 5'd27, 4'h0, 0, 1, 1'b0, 1'b1);
        run_cycle(0, 0, 0, 0, 5'd0,  4'h0, 0, 0, 1'b1, 1'b1);

`ifdef RV32V_EXMEM_PERF_EN
        run_cycle(1, 0, 0, 0, 5'd0, 4'h0, 0, 0, 1'b0, 1'b0);
        check("stall_reset",   stall_cycles, 32'd0);
        check("flushed_reset", flushed_entries, 32'd0);
        run_cycle(0, 0, 1, 0, 5'd1, 4'h0, 0, 0, 1'b1, 1'b1);
        run_cycle(0, 0, 1, 0, 5'd2, 4'h0, 0, 1, 1'b1, 1'b1);   // stall 1
        run_cycle(0, 0, 0, 0, 5'd0, 4'h0, 0, 2, 1'b0, 1'b1);   // stall 2
        run_cycle(0, 0, 0, 0, 5'd0, 4'h0, 0, 2, 1'b0, 1'b1);   // stall 3
        run_cycle(0, 1, 0, 1, 5'd0, 4'h0, 0, 2, 1'b0, 1'b1);   // flush 2 entries
        check("stall_cycles",    stall_cycles, 32'd3);
        check("flushed_entries", flushed_entries, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
